piso_serializer: RTL and testbench

- Parallel-in/serial-out stage that sits directly upstream of the serial sequence detectors.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on ser_out, which feeds a detector's serial data input.
- A one-word holding register lets the next word be accepted while the current word shifts, so frames can run back-to-back.

---
 rtl/seq_pkg.sv | 12 +
 rtl/piso_serializer.sv | 124 ++++++++++++
 tb/tb_piso_serializer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - state encodings and counter sizing shared by the serial datapath blocks
package seq_pkg;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_SHIFT = 2'b01;
   localparam logic [1:0] S_GAP   = 2'b10;

   function automatic int cnt_width(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out stage with a one-word holding register
module piso_serializer
   import seq_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int MSB_FIRST  = 1,
   parameter int GAP_CYCLES = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_last,
   output logic             busy
);

   localparam int              CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0]   BIT_LAST = CW'(WIDTH - 1);
   localparam logic [7:0]      GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

   logic [1:0]       state_q, state_d;
   logic             hold_full_q, hold_full_d;
   logic [WIDTH-1:0] hold_reg_q, hold_reg_d;
   logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]       gap_cnt_q, gap_cnt_d;
   logic             ser_out_q, ser_out_d;
   logic             ser_valid_q, ser_valid_d;
   logic             ser_last_q, ser_last_d;
   logic             transfer;

   always_comb begin
      state_d     = state_q;
      hold_full_d = hold_full_q;
      hold_reg_d  = hold_reg_q;
      shift_reg_d = shift_reg_q;
      bit_cnt_d   = bit_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      ser_out_d   = 1'b0;
      ser_valid_d = 1'b0;
      transfer    = 1'b0;

      case (state_q)
         S_IDLE: transfer = hold_full_q;
         S_SHIFT: begin
            if (bit_cnt_q == BIT_LAST) begin
               if (GAP_CYCLES > 0) begin
                  state_d   = S_GAP;
                  gap_cnt_d = 8'd0;
               end else if (hold_full_q) begin
                  transfer = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               bit_cnt_d   = bit_cnt_q + CW'(1);
               shift_reg_d = (MSB_FIRST != 0) ? (shift_reg_q << 1) : (shift_reg_q >> 1);
               ser_out_d   = (MSB_FIRST != 0) ? shift_reg_q[WIDTH-2] : shift_reg_q[1];
               ser_valid_d = 1'b1;
            end
         end
         S_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               if (hold_full_q) transfer = 1'b1;
               else             state_d  = S_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // The first bit goes out on the transfer edge itself, so back-to-back words have no bubble.
      if (transfer) begin
         state_d     = S_SHIFT;
         shift_reg_d = hold_reg_q;
         hold_full_d = 1'b0;
         bit_cnt_d   = '0;
         ser_out_d   = (MSB_FIRST != 0) ? hold_reg_q[WIDTH-1] : hold_reg_q[0];
         ser_valid_d = 1'b1;
      end

      if (load_valid && !hold_full_q) begin
         hold_reg_d  = data_in;
         hold_full_d = 1'b1;
      end

      ser_last_d = ser_valid_d && (bit_cnt_d == BIT_LAST);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         hold_full_q <= 1'b0;
         hold_reg_q  <= '0;
         shift_reg_q <= '0;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= 8'd0;
         ser_out_q   <= 1'b0;
         ser_valid_q <= 1'b0;
         ser_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_full_q <= hold_full_d;
         hold_reg_q  <= hold_reg_d;
         shift_reg_q <= shift_reg_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         ser_out_q   <= ser_out_d;
         ser_valid_q <= ser_valid_d;
         ser_last_q  <= ser_last_d;
      end
   end

   assign load_ready = !hold_full_q;
   assign ser_out    = ser_out_q;
   assign ser_valid  = ser_valid_q;
   assign ser_last   = ser_last_q;
   assign busy       = (state_q != S_IDLE) || hold_full_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - timeline-model bench for two serializer configurations
module tb_piso_serializer;

   localparam int W    = 8;
   localparam int MAXC = 4096;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [1:0]      lv  = '0;
   logic [1:0][7:0] din = '0;
   logic [1:0]      rdy, so, sv, sl, bz;

   int total = 0;
   int bad   = 0;
   int n     = 0;
   int det   = 0;
   logic [2:0] hist = 3'b000;

   // expected outputs per DUT, indexed by the edge after which they are visible
   bit ev  [2][MAXC];
   bit eb  [2][MAXC];
   bit el  [2][MAXC];
   bit ebz [2][MAXC];
   int t_last [2];
   bit acc [2];

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(0)) u_dut0 (
      .clock(clk), .reset(rst), .data_in(din[0]), .load_valid(lv[0]),
      .load_ready(rdy[0]), .ser_out(so[0]), .ser_valid(sv[0]), .ser_last(sl[0]), .busy(bz[0])
   );

   piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(2)) u_dut1 (
      .clock(clk), .reset(rst), .data_in(din[1]), .load_valid(lv[1]),
      .load_ready(rdy[1]), .ser_out(so[1]), .ser_valid(sv[1]), .ser_last(sl[1]), .busy(bz[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // A word accepted at edge a starts at edge max(a+1, previous start + W + gap) and
   // frees the holding register at that same edge.
   function automatic void model_edge(input int d);
      int  g   = (d == 0) ? 0 : 2;
      bit  msb = (d == 0);
      int  t;
      acc[d] = 1'b0;
      if (rst) begin
         for (int c = n; c < MAXC; c++) begin
            ev[d][c] = 1'b0; eb[d][c] = 1'b0; el[d][c] = 1'b0; ebz[d][c] = 1'b0;
         end
         t_last[d] = -1000;
      end else if (lv[d] && (t_last[d] < n)) begin
         acc[d] = 1'b1;
         t = (t_last[d] + W + g > n + 1) ? (t_last[d] + W + g) : (n + 1);
         for (int k = 0; k < W; k++) begin
            if (t + k < MAXC) begin
               ev[d][t+k] = 1'b1;
               eb[d][t+k] = msb ? din[d][W-1-k] : din[d][k];
               el[d][t+k] = (k == W - 1);
            end
         end
         for (int c = n; (c <= t + W + g - 1) && (c < MAXC); c++) ebz[d][c] = 1'b1;
         t_last[d] = t;
      end
   endfunction

   task automatic compare(input int d);
      check($sformatf("d%0d_valid@%0d", d, n), 32'(sv[d]), 32'(ev[d][n]));
      check($sformatf("d%0d_out@%0d", d, n), 32'(so[d]), 32'(eb[d][n]));
      check($sformatf("d%0d_last@%0d", d, n), 32'(sl[d]), 32'(el[d][n]));
      check($sformatf("d%0d_ready@%0d", d, n), 32'(rdy[d]), 32'(t_last[d] <= n));
      check($sformatf("d%0d_busy@%0d", d, n), 32'(bz[d]), 32'(ebz[d][n]));
   endtask

   task automatic step();
      @(posedge clk);
      n++;
      for (int d = 0; d < 2; d++) model_edge(d);
      @(negedge clk);
      for (int d = 0; d < 2; d++) compare(d);
      hist = {hist[1:0], so[0]};
      if (hist == 3'b101) det++;
   endtask

   // Holds load_valid high until the word is taken; scrambles data_in on edges that cannot accept.
   task automatic push(input int d, input logic [7:0] w);
      lv[d]  = 1'b1;
      din[d] = w;
      for (int i = 0; i < 40; i++) begin
         step();
         if (acc[d]) return;
         din[d] = (t_last[d] <= n) ? w : 8'($urandom);
      end
      check($sformatf("d%0d_push_timeout", d), 32'd0, 32'd1);
   endtask

   initial begin
      t_last[0] = -1000;
      t_last[1] = -1000;

      step();
      step();
      rst = 1'b0;
      repeat (3) step();

      det = 0;
      push(0, 8'hA0);
      lv[0] = 1'b0;
      repeat (10) step();
      check("det101_count_a0", 32'(det), 32'd1);

      push(0, 8'hA5);
      push(0, 8'h3C);
      lv[0] = 1'b0;
      repeat (20) step();

      push(1, 8'h01);
      push(1, 8'h80);
      lv[1] = 1'b0;
      repeat (25) step();

      push(0, 8'hFF);
      push(0, 8'h81);
      lv[0] = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_mid_ready", 32'(rdy[0]), 32'd1);
      check("rst_mid_valid", 32'(sv[0]), 32'd0);
      check("rst_mid_busy", 32'(bz[0]), 32'd0);
      repeat (20) step();

      for (int i = 0; i < 400; i++) begin
         rst    = ($urandom_range(0, 99) == 0);
         lv[0]  = ($urandom_range(0, 2) != 0);
         lv[1]  = ($urandom_range(0, 2) != 0);
         din[0] = 8'($urandom);
         din[1] = 8'($urandom);
         step();
      end
      rst = 1'b0;
      lv  = '0;
      repeat (30) step();
      check("drain_busy0", 32'(bz[0]), 32'd0);
      check("drain_busy1", 32'(bz[1]), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
